// File: rtl/sr595_chain_driver.sv
// sr595_chain_driver
//   Serial driver for a chain of NBYTES 74HC595 shift registers. A word is
//   captured on a four-phase req/ack handshake. It is shifted out on
//   sp_clk/sp_dat at a divided rate and then latched with one sp_ratch pulse.
//
// Parameters
//   NBYTES     number of chained 595s, word width W = 8*NBYTES
//   DIV        clk cycles per sp_clk half-period (>= 1)
//   LSB_FIRST  1: data[0] goes out first, 0: data[W-1] goes out first
//   INVERT     1: sp_dat carries the inverted bit (active-low loads)
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   req       in   transfer request (four-phase)
//   data      in   word to send, sampled only at capture
//   ack       out  transfer complete (four-phase)
//   busy      out  high from capture until ack falls
//   sp_clk    out  595 SRCLK
//   sp_dat    out  595 SER
//   sp_ratch  out  595 RCLK (latch strobe)
module sr595_chain_driver #(
  parameter int NBYTES    = 1,
  parameter int DIV       = 1,
  parameter int LSB_FIRST = 1,
  parameter int INVERT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [8*NBYTES-1:0]   data,
  output logic                  ack,
  output logic                  busy,
  output logic                  sp_clk,
  output logic                  sp_dat,
  output logic                  sp_ratch
);

  localparam int W   = 8 * NBYTES;
  localparam int DCW = $clog2(DIV + 1);
  localparam int BCW = $clog2(W) + 1;

  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);
  localparam logic           INV      = (INVERT != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, ACK} state_t;

  state_t         state;
  logic [W-1:0]   shreg;
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;
  logic           div_end;

  // The bit about to go out always sits at the leading end of shreg, so the
  // line value is taken from there with the polarity applied.
  function automatic logic lead_bit(input logic [W-1:0] v);
    return ((LSB_FIRST != 0) ? v[0] : v[W-1]) ^ INV;
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  assign div_end = (div_cnt == DIV_LAST);

  // One FSM drives every output from a register. In SHIFT the divider
  // marks the end of each half-period. A low->high end raises sp_clk. A
  // high->low end drops sp_clk and presents the next bit on the same edge,
  // which gives a full half-period of setup and hold around each rising edge.
  // After the last bit's high phase the latch strobe is held for one
  // half-period, and then ack is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      sp_clk   <= 1'b0;
      sp_dat   <= 1'b0;
      sp_ratch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !ack) begin
            shreg   <= data;
            busy    <= 1'b1;
            sp_clk  <= 1'b0;
            sp_dat  <= lead_bit(data);
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          div_cnt <= div_end ? '0 : div_cnt + 1'b1;
          if (div_end) begin
            if (!sp_clk) begin
              sp_clk <= 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
              sp_clk   <= 1'b0;
              sp_ratch <= 1'b1;
              state    <= LATCH;
            end else begin
              sp_clk  <= 1'b0;
              shreg   <= advance(shreg);
              sp_dat  <= lead_bit(advance(shreg));
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        LATCH: begin
          div_cnt <= div_end ? '0 : div_cnt + 1'b1;
          if (div_end) begin
            sp_ratch <= 1'b0;
            ack      <= 1'b1;
            state    <= ACK;
          end
        end

        ACK: begin
          // ack holds until the requester withdraws req.
          if (!req) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
